// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the pipelined datapath. Owns the PC register, the
// instruction-memory read request and the IF/ID pipeline latch. A redirect
// (taken branch or jump) that arrives while the current fetch has not yet
// completed is parked in pend_target and applied when that fetch completes, so
// the wrong-path instruction returned by that fetch never enters IF/ID. A
// retired halt freezes the stage until reset.
//
// Parameters:
//   PC_INIT        PC value after reset
//
// Ports:
//   CLK            in   system clock, rising-edge active
//   nRST           in   synchronous active-low reset
//   pc_en          in   hazard-unit PC enable
//   stall_ifid     in   hold the IF/ID latch
//   flush_ifid     in   bubble the IF/ID latch (beats stall)
//   halt           in   halt retired; sticky stop until reset
//   branch_taken   in   taken branch resolved this cycle
//   branch_target  in   branch destination
//   jump           in   jump resolved this cycle
//   jump_target    in   jump destination
//   ihit           in   imemload is valid this cycle
//   imemload       in   fetched instruction
//   imemREN        out  instruction read request
//   imemaddr       out  fetch address (the PC register)
//   ifid_instr     out  IF/ID instruction
//   ifid_npc       out  IF/ID PC+4
//   ifid_valid     out  IF/ID holds a real instruction
// ----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        pc_en,
    input  logic        stall_ifid,
    input  logic        flush_ifid,
    input  logic        halt,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_npc,
    output logic        ifid_valid
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        REDIR = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_n_s;
    logic [31:0] pc_r;
    logic [31:0] pc_n_s;
    logic [31:0] pend_target_r;
    logic [31:0] pend_target_n_s;
    logic [31:0] ifid_instr_r;
    logic [31:0] ifid_npc_r;
    logic        ifid_valid_r;

    logic        adv_s;
    logic        redir_s;
    logic [31:0] tgt_s;
    logic [31:0] pc_plus4_s;
    logic        ifid_load_s;

    // Decode this cycle's advance condition and redirect source.
    always_comb begin
        adv_s      = pc_en & ihit & (state_r != HALT);
        redir_s    = branch_taken | jump;
        pc_plus4_s = pc_r + 32'd4;
        // The branch is the older instruction, so it wins over a jump.
        if (branch_taken) begin
            tgt_s = {branch_target[31:2], 2'b00};
        end else begin
            tgt_s = {jump_target[31:2], 2'b00};
        end
        // Only a right-path fetch completing in RUN with no redirect is kept.
        ifid_load_s = ihit & (state_r == RUN) & ~halt & ~redir_s;
    end

    // Next-state, next-PC and pending-target logic.
    always_comb begin
        state_n_s       = state_r;
        pc_n_s          = pc_r;
        pend_target_n_s = pend_target_r;
        if (halt) begin
            // Halt overrides every other event; pc freezes where it is.
            state_n_s = HALT;
        end else begin
            case (state_r)
                RUN: begin
                    if (adv_s && redir_s) begin
                        pc_n_s = tgt_s;
                    end else if (adv_s) begin
                        pc_n_s = pc_plus4_s;
                    end else if (redir_s) begin
                        // Fetch still outstanding: park the target, keep the
                        // address stable for the memory side.
                        pend_target_n_s = tgt_s;
                        state_n_s       = REDIR;
                    end else begin
                        pc_n_s = pc_r;
                    end
                end
                REDIR: begin
                    if (redir_s) begin
                        pend_target_n_s = tgt_s;
                    end else begin
                        pend_target_n_s = pend_target_r;
                    end
                    if (adv_s) begin
                        pc_n_s    = redir_s ? tgt_s : pend_target_r;
                        state_n_s = RUN;
                    end else begin
                        pc_n_s = pc_r;
                    end
                end
                HALT: begin
                    state_n_s = HALT;
                end
                default: begin
                    // Unreachable encoding: stop fetching rather than guess.
                    state_n_s = HALT;
                end
            endcase
        end
    end

    // PC, pending target and control state registers.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_r       <= RUN;
            pc_r          <= PC_INIT;
            pend_target_r <= 32'h0000_0000;
        end else begin
            state_r       <= state_n_s;
            pc_r          <= pc_n_s;
            pend_target_r <= pend_target_n_s;
        end
    end

    // IF/ID pipeline latch: flush, then stall, then load, else bubble.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            ifid_instr_r <= 32'h0000_0000;
            ifid_npc_r   <= 32'h0000_0000;
            ifid_valid_r <= 1'b0;
        end else if (flush_ifid) begin
            ifid_instr_r <= 32'h0000_0000;
            ifid_npc_r   <= 32'h0000_0000;
            ifid_valid_r <= 1'b0;
        end else if (stall_ifid) begin
            ifid_instr_r <= ifid_instr_r;
            ifid_npc_r   <= ifid_npc_r;
            ifid_valid_r <= ifid_valid_r;
        end else if (ifid_load_s) begin
            ifid_instr_r <= imemload;
            ifid_npc_r   <= pc_plus4_s;
            ifid_valid_r <= 1'b1;
        end else begin
            ifid_instr_r <= 32'h0000_0000;
            ifid_npc_r   <= 32'h0000_0000;
            ifid_valid_r <= 1'b0;
        end
    end

    assign imemREN    = (state_r != HALT);
    assign imemaddr   = pc_r;
    assign ifid_instr = ifid_instr_r;
    assign ifid_npc   = ifid_npc_r;
    assign ifid_valid = ifid_valid_r;

endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed-vector bench for fetch_stage with PC_INIT = 0x40. Inputs are driven
// 1 ns after each rising edge, outputs are sampled at the same point, and every
// expected value below is hand-computed.
// ----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        CLK;
    logic        nRST;
    logic        pc_en;
    logic        stall_ifid;
    logic        flush_ifid;
    logic        halt;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        ihit;
    logic [31:0] imemload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_npc;
    logic        ifid_valid;

    int vectors_r;
    int miscompares_r;

    fetch_stage #(.PC_INIT(32'h0000_0040)) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .pc_en         (pc_en),
        .stall_ifid    (stall_ifid),
        .flush_ifid    (flush_ifid),
        .halt          (halt),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .ihit          (ihit),
        .imemload      (imemload),
        .imemREN       (imemREN),
        .imemaddr      (imemaddr),
        .ifid_instr    (ifid_instr),
        .ifid_npc      (ifid_npc),
        .ifid_valid    (ifid_valid)
    );

    // Free-running clock, 10 ns period.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Single comparison point: counts the vector and reports a miscompare.
    task automatic check_value(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        vectors_r = vectors_r + 1;
        if (obs !== exp) begin
            miscompares_r = miscompares_r + 1;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] instr,
                              input logic [31:0] npc, input logic valid);
        check_value({tag, ".instr"}, ifid_instr, instr);
        check_value({tag, ".npc"}, ifid_npc, npc);
        check_value({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, valid});
    endtask

    task automatic set_redir(input logic br, input logic [31:0] bt,
                             input logic jp, input logic [31:0] jt);
        branch_taken  = br;
        branch_target = bt;
        jump          = jp;
        jump_target   = jt;
    endtask

    initial begin
        vectors_r     = 0;
        miscompares_r = 0;
        nRST          = 1'b0;
        pc_en         = 1'b0;
        stall_ifid    = 1'b0;
        flush_ifid    = 1'b0;
        halt          = 1'b0;
        ihit          = 1'b0;
        imemload      = 32'h0000_0000;
        set_redir(1'b0, 32'h0, 1'b0, 32'h0);

        // Reset state.
        step();
        step();
        check_value("rst.ren", {31'd0, imemREN}, 32'd1);
        check_value("rst.addr", imemaddr, 32'h0000_0040);
        check_ifid("rst", 32'h0, 32'h0, 1'b0);

        // Sequential fetch of 0xA, 0xB, 0xC.
        nRST  = 1'b1;
        pc_en = 1'b1;
        ihit  = 1'b1;
        imemload = 32'h0000_000A;
        step();
        check_value("seq1.addr", imemaddr, 32'h0000_0044);
        check_ifid("seq1", 32'h0000_000A, 32'h0000_0044, 1'b1);
        imemload = 32'h0000_000B;
        step();
        check_value("seq2.addr", imemaddr, 32'h0000_0048);
        check_ifid("seq2", 32'h0000_000B, 32'h0000_0048, 1'b1);
        imemload = 32'h0000_000C;
        step();
        check_value("seq3.addr", imemaddr, 32'h0000_004C);
        check_ifid("seq3", 32'h0000_000C, 32'h0000_004C, 1'b1);

        // Stall two cycles with pc_en low, then stall+flush.
        pc_en      = 1'b0;
        stall_ifid = 1'b1;
        imemload   = 32'h0000_000D;
        for (int i = 0; i < 2; i++) begin
            step();
            check_value("stall.addr", imemaddr, 32'h0000_004C);
            check_ifid("stall", 32'h0000_000C, 32'h0000_004C, 1'b1);
        end
        flush_ifid = 1'b1;
        step();
        check_value("flush.addr", imemaddr, 32'h0000_004C);
        check_ifid("flush", 32'h0, 32'h0, 1'b0);

        // Plain miss: address stable, request held.
        stall_ifid = 1'b0;
        flush_ifid = 1'b0;
        pc_en      = 1'b1;
        ihit       = 1'b0;
        step();
        check_value("miss.addr", imemaddr, 32'h0000_004C);
        check_value("miss.ren", {31'd0, imemREN}, 32'd1);

        // Branch during a miss: parked, then applied on the next hit.
        set_redir(1'b1, 32'h0000_0103, 1'b0, 32'h0);
        step();
        check_value("rmiss.addr", imemaddr, 32'h0000_004C);
        check_ifid("rmiss", 32'h0, 32'h0, 1'b0);
        set_redir(1'b0, 32'h0, 1'b0, 32'h0);
        ihit     = 1'b1;
        imemload = 32'h0000_00EE;
        step();
        check_value("rhit.addr", imemaddr, 32'h0000_0100);
        check_ifid("rhit", 32'h0, 32'h0, 1'b0);

        // Branch and jump together with advance: branch wins.
        set_redir(1'b1, 32'h0000_0200, 1'b1, 32'h0000_0300);
        imemload = 32'h0000_00FF;
        step();
        check_value("bj.addr", imemaddr, 32'h0000_0200);
        check_ifid("bj", 32'h0, 32'h0, 1'b0);

        // Jump alone, low target bits forced to zero.
        set_redir(1'b0, 32'h0, 1'b1, 32'h0000_0301);
        step();
        check_value("jmp.addr", imemaddr, 32'h0000_0300);
        set_redir(1'b0, 32'h0, 1'b0, 32'h0);
        imemload = 32'h0000_0011;
        step();
        check_value("post.addr", imemaddr, 32'h0000_0304);
        check_ifid("post", 32'h0000_0011, 32'h0000_0304, 1'b1);

        // Second redirect while parked overwrites the first.
        ihit = 1'b0;
        set_redir(1'b1, 32'h0000_0600, 1'b0, 32'h0);
        step();
        set_redir(1'b0, 32'h0, 1'b1, 32'h0000_0700);
        step();
        check_value("ovr.hold", imemaddr, 32'h0000_0304);
        set_redir(1'b0, 32'h0, 1'b0, 32'h0);
        ihit = 1'b1;
        step();
        check_value("ovr.addr", imemaddr, 32'h0000_0700);

        // Parked redirect with a fresh redirect on the completing hit.
        ihit = 1'b0;
        set_redir(1'b1, 32'h0000_0800, 1'b0, 32'h0);
        step();
        ihit = 1'b1;
        set_redir(1'b0, 32'h0, 1'b1, 32'h0000_0900);
        step();
        check_value("fresh.addr", imemaddr, 32'h0000_0900);
        set_redir(1'b0, 32'h0, 1'b0, 32'h0);

        // Reset while a redirect is parked clears it.
        ihit = 1'b0;
        set_redir(1'b1, 32'h0000_0A00, 1'b0, 32'h0);
        step();
        set_redir(1'b0, 32'h0, 1'b0, 32'h0);
        nRST = 1'b0;
        step();
        check_value("rrst.addr", imemaddr, 32'h0000_0040);
        nRST = 1'b1;
        ihit = 1'b1;
        imemload = 32'h0000_0055;
        step();
        check_value("rrst.next", imemaddr, 32'h0000_0044);
        check_ifid("rrst", 32'h0000_0055, 32'h0000_0044, 1'b1);

        // Halt with a simultaneous redirect, then stay frozen.
        halt = 1'b1;
        set_redir(1'b1, 32'h0000_0500, 1'b0, 32'h0);
        imemload = 32'h0000_0022;
        step();
        check_value("halt.ren", {31'd0, imemREN}, 32'd0);
        check_value("halt.addr", imemaddr, 32'h0000_0044);
        check_ifid("halt", 32'h0, 32'h0, 1'b0);
        halt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_redir(i[0], 32'h0000_0600, ~i[0], 32'h0000_0700);
            step();
            check_value("hfrz.ren", {31'd0, imemREN}, 32'd0);
            check_value("hfrz.addr", imemaddr, 32'h0000_0044);
        end
        set_redir(1'b0, 32'h0, 1'b0, 32'h0);
        nRST = 1'b0;
        step();
        check_value("hrst.addr", imemaddr, 32'h0000_0040);
        check_value("hrst.ren", {31'd0, imemREN}, 32'd1);
        nRST = 1'b1;

        // Wrap: jump to 0xFFFF_FFFC, then fetch from it.
        set_redir(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        step();
        check_value("wrap.pc", imemaddr, 32'hFFFF_FFFC);
        set_redir(1'b0, 32'h0, 1'b0, 32'h0);
        imemload = 32'h0000_0033;
        step();
        check_value("wrap.addr", imemaddr, 32'h0000_0000);
        check_ifid("wrap", 32'h0000_0033, 32'h0000_0000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_r, miscompares_r);
        $finish;
    end

endmodule
